control_sequencer: RTL and testbench

Multi-cycle control FSM that fetches a 9-bit instruction and decodes its 4-bit `op_mne` opcode into per-cycle datapath strobes. Opcode encoding comes from package `definitions`. It sits between the instruction ROM/PC unit and the register file, ALU and data memory. It runs a program from a `Start` pulse until `STOP`, then reports `Done` and a cycle count.

---
 rtl/control_sequencer.sv | 146 ++++++++++++++
 tb/tb_control_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Multi-cycle control FSM: fetches an instruction, decodes its opcode and
// sequences the per-cycle datapath strobes until STOP, then reports Done and a cycle count.
package definitions;
    typedef enum logic [3:0] {
        ADDi   = 4'd0,
        ADDr   = 4'd1,
        CMP    = 4'd2,
        XORr   = 4'd3,
        ORRr   = 4'd4,
        ANDr   = 4'd5,
        MOVr   = 4'd6,
        STRm   = 4'd7,
        LDR    = 4'd8,
        LSL    = 4'd9,
        Badd   = 4'd10,
        RXOR   = 4'd11,
        MOVrhl = 4'd12,
        Bsub   = 4'd13,
        Label  = 4'd14,
        STOP   = 4'd15
    } op_mne_t;
endpackage

module control_sequencer
    import definitions::*;
#(
    parameter int IW = 9,
    parameter int CW = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [IW-1:0] Instr,
    input  logic          CmpFlag,
    output logic          PcInit,
    output logic          PcEn,
    output logic          BranchEn,
    output logic          BranchDir,
    output logic [3:0]    AluOp,
    output logic          AluSrcImm,
    output logic          RegWrEn,
    output logic          RegSrcMem,
    output logic          FlagWrEn,
    output logic          MemRdEn,
    output logic          MemWrEn,
    output logic          Done,
    output logic [CW-1:0] CycleCnt
);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT
    } state_t;

    state_t        state_q, state_d;
    op_mne_t       ir_q, ir_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Only the opcode field drives control; operand bits belong to the datapath.
    logic unused_operand;
    assign unused_operand = ^Instr[IW-5:0];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            ir_q    <= ADDi;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        cnt_d     = cnt_q;
        PcInit    = 1'b0;
        PcEn      = 1'b0;
        BranchEn  = 1'b0;
        RegWrEn   = 1'b0;
        RegSrcMem = 1'b0;
        FlagWrEn  = 1'b0;
        MemRdEn   = 1'b0;
        MemWrEn   = 1'b0;

        if (state_q != IDLE && state_q != HALT && cnt_q != '1)
            cnt_d = cnt_q + CW'(1);

        case (state_q)
            IDLE, HALT: begin
                if (Start) begin
                    PcInit  = 1'b1;
                    cnt_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                ir_d    = op_mne_t'(Instr[IW-1:IW-4]);
                state_d = DECODE;
            end
            DECODE: begin
                case (ir_q)
                    STOP:      state_d = HALT;
                    STRm, LDR: state_d = MEM;
                    default:   state_d = EXEC;
                endcase
            end
            EXEC: begin
                PcEn    = 1'b1;
                state_d = FETCH;
                case (ir_q)
                    CMP:        FlagWrEn = 1'b1;
                    Badd, Bsub: BranchEn = CmpFlag;
                    ADDi, ADDr, XORr, ORRr, ANDr, MOVr, LSL, RXOR, MOVrhl:
                                RegWrEn  = 1'b1;
                    default:    ;
                endcase
            end
            MEM: begin
                if (ir_q == LDR) begin
                    MemRdEn = 1'b1;
                    state_d = WB;
                end else begin
                    MemWrEn = 1'b1;
                    PcEn    = 1'b1;
                    state_d = FETCH;
                end
            end
            WB: begin
                RegWrEn   = 1'b1;
                RegSrcMem = 1'b1;
                PcEn      = 1'b1;
                state_d   = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    assign AluOp     = ir_q;
    assign AluSrcImm = (ir_q == ADDi) || (ir_q == LSL);
    assign BranchDir = (ir_q == Bsub);
    assign Done      = (state_q == HALT);
    assign CycleCnt  = cnt_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: random programs checked cycle by
// cycle against an expected-trace model built from per-opcode cycle profiles.
module tb_control_sequencer;

    logic       Clk = 1'b0;
    logic       Reset, Start, CmpFlag;
    logic [8:0] Instr;

    logic        a_pcinit, a_pcen, a_bren, a_brdir, a_aluimm, a_regwr, a_regmem;
    logic        a_flagwr, a_memrd, a_memwr, a_done;
    logic [3:0]  a_aluop;
    logic [15:0] a_cnt;
    logic        b_pcinit, b_pcen, b_bren, b_brdir, b_aluimm, b_regwr, b_regmem;
    logic        b_flagwr, b_memrd, b_memwr, b_done;
    logic [3:0]  b_aluop;
    logic [3:0]  b_cnt;

    always #5 Clk = ~Clk;

    control_sequencer #(.IW(9), .CW(16)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Instr(Instr), .CmpFlag(CmpFlag),
        .PcInit(a_pcinit), .PcEn(a_pcen), .BranchEn(a_bren), .BranchDir(a_brdir),
        .AluOp(a_aluop), .AluSrcImm(a_aluimm), .RegWrEn(a_regwr), .RegSrcMem(a_regmem),
        .FlagWrEn(a_flagwr), .MemRdEn(a_memrd), .MemWrEn(a_memwr), .Done(a_done),
        .CycleCnt(a_cnt)
    );

    control_sequencer #(.IW(9), .CW(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Instr(Instr), .CmpFlag(CmpFlag),
        .PcInit(b_pcinit), .PcEn(b_pcen), .BranchEn(b_bren), .BranchDir(b_brdir),
        .AluOp(b_aluop), .AluSrcImm(b_aluimm), .RegWrEn(b_regwr), .RegSrcMem(b_regmem),
        .FlagWrEn(b_flagwr), .MemRdEn(b_memrd), .MemWrEn(b_memwr), .Done(b_done),
        .CycleCnt(b_cnt)
    );

    // Simple PC unit and instruction ROM; branches are not followed.
    logic [8:0] prog [0:31];
    int pc;
    always @(posedge Clk or posedge Reset) begin
        if (Reset)         pc <= 0;
        else if (a_pcinit) pc <= 0;
        else if (a_pcen)   pc <= pc + 1;
    end
    always_comb Instr = (pc < 32) ? prog[pc] : 9'h1E0;

    localparam logic [8:0] B_INIT = 9'h100, B_PCEN = 9'h080, B_RW  = 9'h020,
                           B_RSM  = 9'h010, B_FW   = 9'h008, B_MRD = 9'h004,
                           B_MWR  = 9'h002, B_DONE = 9'h001;

    typedef struct {
        logic [8:0] s;
        bit         brc;
        bit         chk;
        logic [3:0] op;
    } exp_t;

    exp_t       q[$];
    logic [3:0] ops[$];
    int         vec_cnt = 0;
    int         err_cnt = 0;
    bit         in_halt = 0;
    int         alu_ops[9] = '{0, 1, 3, 4, 5, 6, 9, 11, 12};

    function automatic int mn(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic void add_cyc(input logic [8:0] s, input bit brc, input bit chk,
                                    input logic [3:0] op);
        exp_t e;
        e.s = s; e.brc = brc; e.chk = chk; e.op = op;
        q.push_back(e);
    endfunction

    // Per-opcode cycle profile: FETCH, DECODE, then the class-specific tail.
    function automatic void model_instr(input logic [3:0] op);
        add_cyc(9'h000, 0, 0, op);
        add_cyc(9'h000, 0, 0, op);
        case (op)
            4'd15: ;
            4'd7:  add_cyc(B_MWR | B_PCEN, 0, 0, op);
            4'd8: begin
                add_cyc(B_MRD, 0, 0, op);
                add_cyc(B_RW | B_RSM | B_PCEN, 0, 0, op);
            end
            4'd2:         add_cyc(B_FW | B_PCEN, 0, 1, op);
            4'd10, 4'd13: add_cyc(B_PCEN, 1, 1, op);
            4'd14:        add_cyc(B_PCEN, 0, 1, op);
            default:      add_cyc(B_RW | B_PCEN, 0, 1, op);
        endcase
    endfunction

    function automatic logic [1:0] next_flag(input int cmode);
        return (cmode == 2) ? 2'($urandom_range(0, 1)) : 2'(cmode);
    endfunction

    task automatic run_prog(input string name, input bit hold, input int cmode);
        int h, ecnt;
        logic [8:0] obs, obs4, e_s;
        logic [5:0] o_op, e_op;
        q.delete();
        for (int k = 0; k < 32; k++) prog[k] = {4'd15, 5'($urandom)};
        foreach (ops[k]) prog[k] = {ops[k], 5'($urandom)};
        add_cyc(B_INIT | (in_halt ? B_DONE : 9'h000), 0, 0, 4'd0);
        foreach (ops[k]) model_instr(ops[k]);
        model_instr(4'd15);
        h = q.size();
        add_cyc(B_DONE, 0, 0, 4'd0);
        add_cyc(B_DONE, 0, 0, 4'd0);
        Start   = 1'b1;
        CmpFlag = next_flag(cmode)[0];
        for (int i = 0; i < q.size(); i++) begin
            @(negedge Clk);
            obs  = {a_pcinit, a_pcen, a_bren, a_regwr, a_regmem, a_flagwr, a_memrd, a_memwr, a_done};
            obs4 = {b_pcinit, b_pcen, b_bren, b_regwr, b_regmem, b_flagwr, b_memrd, b_memwr, b_done};
            e_s  = q[i].s;
            if (q[i].brc) e_s[6] = CmpFlag;
            vec_cnt++;
            if (obs !== e_s) begin
                err_cnt++;
                $display("FAIL %s strobes cyc %0d: got %b want %b", name, i, obs, e_s);
            end
            vec_cnt++;
            if (obs4 !== e_s) begin
                err_cnt++;
                $display("FAIL %s strobes_cw4 cyc %0d: got %b want %b", name, i, obs4, e_s);
            end
            if (i > 0) begin
                ecnt = (i < h) ? i - 1 : h - 1;
                vec_cnt++;
                if (a_cnt !== 16'(mn(ecnt, 65535))) begin
                    err_cnt++;
                    $display("FAIL %s cyclecnt cyc %0d: got %0d want %0d", name, i, a_cnt, mn(ecnt, 65535));
                end
                vec_cnt++;
                if (b_cnt !== 4'(mn(ecnt, 15))) begin
                    err_cnt++;
                    $display("FAIL %s cyclecnt_cw4 cyc %0d: got %0d want %0d", name, i, b_cnt, mn(ecnt, 15));
                end
            end
            if (q[i].chk) begin
                o_op = {a_aluop, a_aluimm, a_brdir};
                e_op = {q[i].op, (q[i].op == 4'd0 || q[i].op == 4'd9), (q[i].op == 4'd13)};
                vec_cnt++;
                if (o_op !== e_op) begin
                    err_cnt++;
                    $display("FAIL %s aluop cyc %0d: got %b want %b", name, i, o_op, e_op);
                end
            end
            @(posedge Clk);
            #1;
            Start   = hold && (i + 1 < h);
            CmpFlag = next_flag(cmode)[0];
        end
        Start   = 1'b0;
        in_halt = 1;
    endtask

    task automatic test_reset;
        Reset = 1'b1; Start = 1'b0; CmpFlag = 1'b0;
        for (int k = 0; k < 32; k++) prog[k] = 9'h1E0;
        repeat (2) @(posedge Clk);
        #1;
        vec_cnt++;
        if ({a_pcinit, a_pcen, a_bren, a_regwr, a_regmem, a_flagwr, a_memrd, a_memwr, a_done, a_cnt} !== 25'd0) begin
            err_cnt++;
            $display("FAIL reset_state: got strobes %b cnt %0d want 0", {a_pcen, a_regwr, a_done}, a_cnt);
        end
        Reset = 1'b0;
        in_halt = 0;
    endtask

    task automatic test_fixed_program;
        ops = '{4'd0, 4'd8};
        run_prog("addi_ldr_stop", 0, 2);
    endtask

    task automatic test_branch;
        ops = '{4'd2, 4'd13};
        run_prog("cmp_bsub_f1", 0, 1);
        ops = '{4'd2, 4'd13, 4'd10};
        run_prog("cmp_bsub_f0", 0, 0);
    endtask

    task automatic test_store_label;
        ops = '{4'd7, 4'd14};
        run_prog("strm_label", 0, 2);
    endtask

    task automatic test_back_to_back;
        ops = '{4'd1, 4'd8, 4'd7};
        run_prog("start_held", 1, 2);
        ops = '{4'd11, 4'd2};
        run_prog("restart", 0, 2);
    endtask

    task automatic test_random;
        for (int p = 0; p < 6; p++) begin
            ops.delete();
            for (int k = 0; k < int'($urandom_range(2, 7)); k++)
                ops.push_back(4'($urandom_range(0, 14)));
            run_prog("random", p[0], 2);
        end
    endtask

    task automatic test_saturation;
        ops.delete();
        for (int k = 0; k < 8; k++) ops.push_back(4'(alu_ops[$urandom_range(0, 8)]));
        run_prog("saturate", 0, 2);
    endtask

    task automatic test_reset_mid_exec;
        for (int k = 0; k < 32; k++) prog[k] = 9'h1E0;
        prog[0] = {4'd1, 5'($urandom)};
        Start = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge Clk);
            #1;
            Start = 1'b0;
        end
        @(negedge Clk);
        vec_cnt++;
        if (a_regwr !== 1'b1) begin
            err_cnt++;
            $display("FAIL mid_exec_regwr: got %b want 1", a_regwr);
        end
        Reset = 1'b1;
        #1;
        vec_cnt++;
        if ({a_regwr, a_pcen, a_done, a_cnt, b_regwr, b_cnt} !== 23'd0) begin
            err_cnt++;
            $display("FAIL reset_mid_exec: got regwr %b pcen %b done %b cnt %0d want 0",
                     a_regwr, a_pcen, a_done, a_cnt);
        end
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(negedge Clk);
        vec_cnt++;
        if ({a_pcinit, a_pcen, a_bren, a_regwr, a_regmem, a_flagwr, a_memrd, a_memwr, a_done, a_cnt} !== 25'd0) begin
            err_cnt++;
            $display("FAIL after_reset_idle: got done %b cnt %0d want 0", a_done, a_cnt);
        end
        in_halt = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_fixed_program;
        test_branch;
        test_store_label;
        test_back_to_back;
        test_random;
        test_saturation;
        test_reset_mid_exec;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
